// File: rtl/seq_add_sub_if.sv
// Operand/result bundle for the multi-cycle adder/subtractor.
// The master presents operands; the slave (the adder) returns result and flags.
interface seq_add_sub_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] in2;
    logic             sub;
    logic             done;
    logic [WIDTH-1:0] out;
    logic             cout;
    logic             ovf;

    modport master (output in_valid, in1, in2, sub,
                    input  in_ready, done, out, cout, ovf);
    modport slave  (input  in_valid, in1, in2, sub,
                    output in_ready, done, out, cout, ovf);
endinterface

// File: rtl/seq_add_sub.sv
// Multi-cycle adder/subtractor: sums CHUNK bits per cycle, low chunk first,
// with the inter-chunk carry held in a register. Results are held until the next completion.
module seq_add_sub #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    seq_add_sub_if.slave bus
);
    localparam int NCH = WIDTH / CHUNK;
    localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state;
    logic [WIDTH-1:0] a, b, acc, acc_nxt, out_q;
    logic [WIDTH-1:0] a_sh, b_sh;
    logic             carry, done_q, cout_q, ovf_q;
    logic [IW-1:0]    idx;
    logic [31:0]      sh;
    logic [CHUNK:0]   sum;
    logic             last;

    // Chunk selection by shift/mask so NCH = 1 needs no special casing.
    always_comb begin
        sh      = 32'(idx) * 32'(CHUNK);
        a_sh    = a >> sh;
        b_sh    = b >> sh;
        sum     = {1'b0, a_sh[CHUNK-1:0]} + {1'b0, b_sh[CHUNK-1:0]} + {{CHUNK{1'b0}}, carry};
        acc_nxt = (acc & ~(WIDTH'({CHUNK{1'b1}}) << sh)) | (WIDTH'(sum[CHUNK-1:0]) << sh);
        last    = (idx == IW'(NCH - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            a      <= '0;
            b      <= '0;
            acc    <= '0;
            carry  <= 1'b0;
            idx    <= '0;
            out_q  <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: if (bus.in_valid) begin
                    a     <= bus.in1;
                    b     <= bus.sub ? ~bus.in2 : bus.in2;
                    carry <= bus.sub;
                    idx   <= '0;
                    acc   <= '0;
                    state <= RUN;
                end
                RUN: begin
                    acc   <= acc_nxt;
                    carry <= sum[CHUNK];
                    idx   <= idx + 1'b1;
                    if (last) begin
                        out_q  <= acc_nxt;
                        cout_q <= sum[CHUNK];
                        // b already holds the inverted operand, so one rule covers add and subtract.
                        ovf_q  <= (a[WIDTH-1] == b[WIDTH-1]) & (acc_nxt[WIDTH-1] != a[WIDTH-1]);
                        done_q <= 1'b1;
                        idx    <= '0;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready = (state == IDLE);
    assign bus.done     = done_q;
    assign bus.out      = out_q;
    assign bus.cout     = cout_q;
    assign bus.ovf      = ovf_q;
endmodule

// File: tb/tb_seq_add_sub.sv
// Scoreboard bench for seq_add_sub: the same directed vectors run on CHUNK = 8, 32 and 4,
// each with its own driver, monitor and expected-result queue.
module tb_seq_add_sub;
    localparam int W = 32;

    typedef struct packed {
        logic [31:0] o;
        logic        c;
        logic        v;
        int          cy;
    } exp_t;

    localparam logic [31:0] VA [6] = '{32'hFFFFFFFF, 32'h7FFFFFFF, 32'h00000005,
                                       32'h80000000, 32'h12345678, 32'h00000003};
    localparam logic [31:0] VB [6] = '{32'h00000001, 32'h00000001, 32'h00000007,
                                       32'h00000001, 32'h11111111, 32'h00000001};
    localparam logic        VS [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    localparam logic [31:0] VO [6] = '{32'h00000000, 32'h80000000, 32'hFFFFFFFE,
                                       32'h7FFFFFFF, 32'h23456789, 32'h00000002};
    localparam logic        VC [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    localparam logic        VV [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};

    logic clk = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    function automatic void chk(input string nm, input int g, input logic [31:0] act,
                                input logic [31:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL cfg%0d %s: got %h, expected %h", g, nm, act, expv);
        end
    endfunction

    function automatic exp_t mk(input int v, input int cy);
        exp_t e;
        e.o  = VO[v];
        e.c  = VC[v];
        e.v  = VV[v];
        e.cy = cy;
        return e;
    endfunction

    for (genvar g = 0; g < 3; g++) begin : cfg
        localparam int CH  = (g == 0) ? 8 : ((g == 1) ? 32 : 4);
        localparam int NCH = W / CH;

        logic rst_n_l = 1'b1;
        bit   fin_l   = 1'b0;
        int   cyc     = 0;
        exp_t q[$];
        exp_t e;

        seq_add_sub_if #(.WIDTH(W)) bus ();

        seq_add_sub #(.WIDTH(W), .CHUNK(CH)) dut (
            .clk   (clk),
            .rst_n (rst_n_l),
            .bus   (bus)
        );

        always @(posedge clk) cyc <= cyc + 1;

        // Monitor: every done pulse must match the oldest outstanding expectation.
        always @(negedge clk) begin
            if (bus.done === 1'b1) begin
                if (q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL cfg%0d unexpected_done: got done with out=%h, expected no done", g, bus.out);
                end else begin
                    e = q.pop_front();
                    chk("out",     g, bus.out,          e.o);
                    chk("cout",    g, 32'(bus.cout),    32'(e.c));
                    chk("ovf",     g, 32'(bus.ovf),     32'(e.v));
                    chk("latency", g, 32'(cyc),         32'(e.cy));
                end
            end
        end

        initial begin
            int guard;
            bus.in_valid = 1'b0;
            bus.in1      = '0;
            bus.in2      = '0;
            bus.sub      = 1'b0;
            #1 rst_n_l = 1'b0;
            repeat (3) @(negedge clk);
            rst_n_l = 1'b1;
            @(negedge clk);
            chk("rst_out",      g, bus.out,            32'h0);
            chk("rst_cout",     g, 32'(bus.cout),      32'h0);
            chk("rst_ovf",      g, 32'(bus.ovf),       32'h0);
            chk("rst_done",     g, 32'(bus.done),      32'h0);
            chk("rst_in_ready", g, 32'(bus.in_ready),  32'h1);

            // Single operations: carry ripple, signed overflow, two subtracts.
            for (int v = 0; v < 4; v++) begin
                bus.in1 = VA[v]; bus.in2 = VB[v]; bus.sub = VS[v]; bus.in_valid = 1'b1;
                q.push_back(mk(v, cyc + 1 + NCH));
                @(posedge clk); @(negedge clk);
                bus.in_valid = 1'b0;
                guard = 0;
                while (bus.in_ready !== 1'b1 && guard < 100) begin @(negedge clk); guard++; end
                if (guard >= 100) chk("idle_timeout", g, 32'(bus.in_ready), 32'h1);
            end

            // Held in_valid while busy: junk operands must be ignored, next op accepted at done.
            bus.in1 = VA[4]; bus.in2 = VB[4]; bus.sub = VS[4]; bus.in_valid = 1'b1;
            q.push_back(mk(4, cyc + 1 + NCH));
            @(posedge clk); @(negedge clk);
            bus.in1 = 32'hAAAAAAAA; bus.in2 = 32'h55555555; bus.sub = 1'b1;
            guard = 0;
            while (bus.in_ready !== 1'b1 && guard < 100) begin @(negedge clk); guard++; end
            if (guard >= 100) chk("busy_timeout", g, 32'(bus.in_ready), 32'h1);
            bus.in1 = VA[5]; bus.in2 = VB[5]; bus.sub = VS[5];
            q.push_back(mk(5, cyc + 1 + NCH));
            @(posedge clk); @(negedge clk);
            bus.in_valid = 1'b0;
            guard = 0;
            while (bus.in_ready !== 1'b1 && guard < 100) begin @(negedge clk); guard++; end
            if (guard >= 100) chk("b2b_timeout", g, 32'(bus.in_ready), 32'h1);
            @(negedge clk);

            // Abort: reset mid-operation when the op is long enough to still be running.
            if (NCH >= 3) begin
                bus.in1 = VA[0]; bus.in2 = VB[0]; bus.sub = VS[0]; bus.in_valid = 1'b1;
                @(posedge clk); @(negedge clk);
                bus.in_valid = 1'b0;
            end
            @(posedge clk);
            #2 rst_n_l = 1'b0;
            #1;
            chk("abort_out",      g, bus.out,           32'h0);
            chk("abort_cout",     g, 32'(bus.cout),     32'h0);
            chk("abort_ovf",      g, 32'(bus.ovf),      32'h0);
            chk("abort_done",     g, 32'(bus.done),     32'h0);
            chk("abort_in_ready", g, 32'(bus.in_ready), 32'h1);
            @(negedge clk);
            rst_n_l = 1'b1;
            repeat (NCH + 2) @(negedge clk);
            chk("abort_out_held", g, bus.out, 32'h0);

            // First accept after reset behaves normally.
            bus.in1 = VA[1]; bus.in2 = VB[1]; bus.sub = VS[1]; bus.in_valid = 1'b1;
            q.push_back(mk(1, cyc + 1 + NCH));
            @(posedge clk); @(negedge clk);
            bus.in_valid = 1'b0;
            repeat (NCH + 3) @(negedge clk);
            chk("queue_empty", g, 32'(q.size()), 32'h0);
            fin_l = 1'b1;
        end
    end

    initial begin
        fork
            wait (cfg[0].fin_l && cfg[1].fin_l && cfg[2].fin_l);
            begin
                #200000;
                n_chk++;
                n_fail++;
                $display("FAIL watchdog: got timeout, expected all configurations to finish");
            end
        join_any
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
